// File: rtl/uart_tx_fifo_if.sv
// Host/transmitter-side bundle of the UART transmit FIFO.
// The master drives the strobes and write data; the slave is the FIFO itself.
interface uart_tx_fifo_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  fifo_write_n;
    logic [WIDTH-1:0]      data_in;
    logic                  fifo_read_n;
    logic                  clr_err;
    logic [WIDTH-1:0]      data_out;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output fifo_write_n, data_in, fifo_read_n, clr_err,
        input  data_out, fifo_empty, fifo_full, count, overflow, underflow
    );

    modport slave (
        input  fifo_write_n, data_in, fifo_read_n, clr_err,
        output data_out, fifo_empty, fifo_full, count, overflow, underflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Single-clock, non-fall-through byte FIFO in front of the UART transmitter.
// All outputs are registered; occupancy is tracked by a counter, not pointer compare.
module uart_tx_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_fifo_if.slave   fif
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic                  empty_q;
    logic                  full_q;
    logic [WIDTH-1:0]      dout_p1;
    logic                  ovf_q;
    logic                  udf_q;

    logic rd_acc;
    logic wr_acc;
    logic ovf_evt;
    logic udf_evt;

    // A write into a full FIFO still succeeds when a read frees a slot in the same cycle.
    always_comb begin
        rd_acc    = !fif.fifo_read_n && !empty_q;
        wr_acc    = !fif.fifo_write_n && (!full_q || rd_acc);
        ovf_evt   = !fif.fifo_write_n && !wr_acc;
        udf_evt   = !fif.fifo_read_n && empty_q;
        count_nxt = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count_q + 1'b1;
            2'b01:   count_nxt = count_q - 1'b1;
            default: count_nxt = count_q;
        endcase
    end

    // Storage is not reset; its contents are meaningless while count is zero.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= fif.data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            dout_p1 <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr  <= rd_ptr + 1'b1;
                dout_p1 <= mem[rd_ptr];
            end
            count_q <= count_nxt;
            empty_q <= (count_nxt == '0);
            full_q  <= (count_nxt == FULL_CNT);
            // A fresh error outranks a simultaneous clear.
            if (ovf_evt) begin
                ovf_q <= 1'b1;
            end else if (fif.clr_err) begin
                ovf_q <= 1'b0;
            end
            if (udf_evt) begin
                udf_q <= 1'b1;
            end else if (fif.clr_err) begin
                udf_q <= 1'b0;
            end
        end
    end

    assign fif.data_out   = dout_p1;
    assign fif.fifo_empty = empty_q;
    assign fif.fifo_full  = full_q;
    assign fif.count      = count_q;
    assign fif.overflow   = ovf_q;
    assign fif.underflow  = udf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: vector table for control/flags, queue model for read data.
module tb_uart_tx_fifo;

    logic clk;
    logic reset;

    uart_tx_fifo_if #(.WIDTH(8), .ADDR_WIDTH(4)) bus ();

    uart_tx_fifo #(.WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .fif   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       wr;
        logic [7:0] din;
        bit       rd;
        bit       clr;
        int       idle;
        int       cnt;
        bit       ovf;
        bit       udf;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] mdl[$];
    logic [7:0] exp_q[$];
    logic [7:0] last_dout;
    int         checks;
    int         errors;

    function automatic void add(bit wr, logic [7:0] din, bit rd, bit clr,
                                int idle, int cnt, bit ovf, bit udf);
        vec_t v;
        v.wr = wr; v.din = din; v.rd = rd; v.clr = clr;
        v.idle = idle; v.cnt = cnt; v.ovf = ovf; v.udf = udf;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(int cnt, bit ovf, bit udf);
        chk("count",      32'(bus.count),      32'(cnt));
        chk("fifo_empty", 32'(bus.fifo_empty), 32'(cnt == 0));
        chk("fifo_full",  32'(bus.fifo_full),  32'(cnt == 16));
        chk("overflow",   32'(bus.overflow),   32'(ovf));
        chk("underflow",  32'(bus.underflow),  32'(udf));
        chk("data_out",   32'(bus.data_out),   32'(last_dout));
    endtask

    // Drive one cycle of strobes, advance the model, and retire any expected read byte.
    task automatic apply(bit wr, logic [7:0] din, bit rd, bit clr);
        int sz;
        bit ra;
        bit wa;
        sz = mdl.size();
        ra = rd && (sz > 0);
        wa = wr && ((sz < 16) || ra);
        if (ra) exp_q.push_back(mdl.pop_front());
        if (wa) mdl.push_back(din);
        bus.fifo_write_n = !wr;
        bus.data_in      = din;
        bus.fifo_read_n  = !rd;
        bus.clr_err      = clr;
        @(posedge clk);
        #1;
        bus.fifo_write_n = 1'b1;
        bus.fifo_read_n  = 1'b1;
        bus.clr_err      = 1'b0;
        if (exp_q.size() > 0) last_dout = exp_q.pop_front();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        last_dout = 8'h00;
        reset     = 1'b1;
        bus.fifo_write_n = 1'b1;
        bus.fifo_read_n  = 1'b1;
        bus.clr_err      = 1'b0;
        bus.data_in      = 8'h00;

        // Three bytes, read back with ten-cycle spacing
        add(1, 8'h41, 0, 0, 0, 1, 0, 0);
        add(1, 8'h42, 0, 0, 0, 2, 0, 0);
        add(1, 8'h43, 0, 0, 2, 3, 0, 0);
        add(0, 8'h00, 1, 0, 9, 2, 0, 0);
        add(0, 8'h00, 1, 0, 9, 1, 0, 0);
        add(0, 8'h00, 1, 0, 2, 0, 0, 0);
        // Fill, overflow, drain, clear
        for (int i = 0; i < 16; i++) add(1, 8'(i), 0, 0, 0, i + 1, 0, 0);
        add(1, 8'hFF, 0, 0, 1, 16, 1, 0);
        for (int i = 0; i < 16; i++) add(0, 8'h00, 1, 0, 0, 15 - i, 1, 0);
        add(0, 8'h00, 0, 1, 0, 0, 0, 0);
        // Fill, simultaneous read/write while full, drain across the wrap
        for (int i = 0; i < 16; i++) add(1, 8'(i), 0, 0, 0, i + 1, 0, 0);
        add(1, 8'hAA, 1, 0, 0, 16, 0, 0);
        for (int i = 0; i < 16; i++) add(0, 8'h00, 1, 0, 0, 15 - i, 0, 0);
        // Empty: read with simultaneous write, then clear-vs-set priority
        add(1, 8'h55, 1, 0, 0, 1, 0, 1);
        add(0, 8'h00, 1, 0, 0, 0, 0, 1);
        add(0, 8'h00, 0, 1, 0, 0, 0, 0);
        add(0, 8'h00, 1, 1, 0, 0, 0, 1);
        add(0, 8'h00, 0, 1, 0, 0, 0, 0);
        // Held-low read strobe drains one byte per cycle, then underflows
        add(1, 8'h11, 0, 0, 0, 1, 0, 0);
        add(1, 8'h22, 0, 0, 0, 2, 0, 0);
        add(0, 8'h00, 1, 0, 0, 1, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0, 1);
        add(0, 8'h00, 0, 1, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check_outputs(0, 0, 0);
        reset = 1'b0;
        apply(0, 8'h00, 0, 0);
        check_outputs(0, 0, 0);

        foreach (vecs[k]) begin
            apply(vecs[k].wr, vecs[k].din, vecs[k].rd, vecs[k].clr);
            check_outputs(vecs[k].cnt, vecs[k].ovf, vecs[k].udf);
            for (int j = 0; j < vecs[k].idle; j++) begin
                apply(0, 8'h00, 0, 0);
                check_outputs(vecs[k].cnt, vecs[k].ovf, vecs[k].udf);
            end
        end

        // Asynchronous reset in the middle of a cycle with five bytes stored
        for (int i = 0; i < 5; i++) apply(1, 8'(8'h60 + i), 0, 0);
        check_outputs(5, 0, 0);
        #3 reset = 1'b1;
        #1;
        mdl.delete();
        exp_q.delete();
        last_dout = 8'h00;
        check_outputs(0, 0, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        apply(1, 8'h77, 0, 0);
        check_outputs(1, 0, 0);
        apply(0, 8'h00, 1, 0);
        check_outputs(0, 0, 0);
        chk("data_out_after_reset", 32'(bus.data_out), 32'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
